// File: rtl/bsg_cycle_counter_pkg.sv
// rtl/bsg_cycle_counter_pkg.sv - shared types and limits for the cycle counter
package bsg_cycle_counter_pkg;

  typedef enum logic {
    e_mode_wrap     = 1'b0,
    e_mode_saturate = 1'b1
  } mode_e;

  localparam int max_width_lp = 64;

endpackage

// File: rtl/bsg_cycle_counter_snap_reg.sv
// rtl/bsg_cycle_counter_snap_reg.sv - one-entry snapshot holding register with valid/yumi handshake
module bsg_cycle_counter_snap_reg
  import bsg_cycle_counter_pkg::*;
#(
  parameter int width_p = max_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic               v_r;
  logic [width_p-1:0] data_r;
  logic               capture;

  // A new capture is only taken when the slot is empty or being drained this cycle.
  assign capture = v_i & (~v_r | yumi_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r    <= 1'b0;
      data_r <= '0;
    end else if (capture) begin
      v_r    <= 1'b1;
      data_r <= data_i;
    end else if (yumi_i) begin
      v_r    <= 1'b0;
    end
  end

  assign v_o    = v_r;
  assign data_o = data_r;

endmodule

// File: rtl/bsg_cycle_counter_snap.sv
// rtl/bsg_cycle_counter_snap.sv - wrap/saturate cycle counter with sticky overflow
// Snapshot path compiled in only when BSG_CYCLE_COUNTER_SNAPSHOT_EN is defined.
module bsg_cycle_counter_snap
  import bsg_cycle_counter_pkg::*;
#(
  parameter int                 width_p    = max_width_lp,
  parameter logic [width_p-1:0] init_val_p = '0,
  parameter int                 saturate_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic               load_v_i,
  input  logic [width_p-1:0] load_data_i,
  output logic [width_p-1:0] ctr_r_o,
  output logic               overflow_r_o,
  input  logic               snap_v_i,
  output logic               snap_v_o,
  output logic [width_p-1:0] snap_data_o,
  input  logic               snap_yumi_i
);

  localparam mode_e mode_lp = (saturate_p != 0) ? e_mode_saturate : e_mode_wrap;
  localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};

  logic [width_p-1:0] ctr_r;
  logic               overflow_r;
  logic               at_max;

  assign at_max = &ctr_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctr_r      <= init_val_p;
      overflow_r <= 1'b0;
    end else if (clear_i) begin
      ctr_r      <= init_val_p;
      overflow_r <= 1'b0;
    end else if (load_v_i) begin
      ctr_r      <= load_data_i;
    end else if (en_i) begin
      if (at_max) begin
        overflow_r <= 1'b1;
        // Saturate mode leaves the all-ones value in place.
        if (mode_lp == e_mode_wrap) ctr_r <= '0;
      end else begin
        ctr_r <= ctr_r + one_lp;
      end
    end
  end

  assign ctr_r_o      = ctr_r;
  assign overflow_r_o = overflow_r;

`ifdef BSG_CYCLE_COUNTER_SNAPSHOT_EN
  bsg_cycle_counter_snap_reg #(
    .width_p(width_p)
  ) snap_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (snap_v_i),
    .data_i (ctr_r),
    .yumi_i (snap_yumi_i),
    .v_o    (snap_v_o),
    .data_o (snap_data_o)
  );
`else
  logic unused_snap;
  assign unused_snap = snap_v_i ^ snap_yumi_i;
  assign snap_v_o    = 1'b0;
  assign snap_data_o = '0;
`endif

endmodule

// File: tb/tb_bsg_cycle_counter_snap.sv
// tb/tb_bsg_cycle_counter_snap.sv - random and directed checks of three counter variants against a reference model
module tb_bsg_cycle_counter_snap;

`ifdef BSG_CYCLE_COUNTER_SNAPSHOT_EN
  localparam bit snap_en_lp = 1'b1;
`else
  localparam bit snap_en_lp = 1'b0;
`endif

  // Instance 0: wrap/init 0, 1: saturate/init 0, 2: wrap/init 8'h10
  localparam int init_m [3] = '{0, 0, 16};
  localparam bit sat_m  [3] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       en_i = 1'b0, clear_i = 1'b0, load_v_i = 1'b0;
  logic [7:0] load_data_i = '0;
  logic       snap_v_i = 1'b0, snap_yumi_i = 1'b0;

  logic [7:0] ctr [3];
  logic       ovf [3];
  logic       sv  [3];
  logic [7:0] sd  [3];

  int  m_ctr [3];
  bit  m_ovf [3];
  int  m_sd  [3];
  bit  m_sv;
  bit  model_ok = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bsg_cycle_counter_snap #(.width_p(8), .init_val_p(8'h00), .saturate_p(0)) dut_w (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i), .load_v_i(load_v_i),
    .load_data_i(load_data_i), .ctr_r_o(ctr[0]), .overflow_r_o(ovf[0]), .snap_v_i(snap_v_i),
    .snap_v_o(sv[0]), .snap_data_o(sd[0]), .snap_yumi_i(snap_yumi_i));

  bsg_cycle_counter_snap #(.width_p(8), .init_val_p(8'h00), .saturate_p(1)) dut_s (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i), .load_v_i(load_v_i),
    .load_data_i(load_data_i), .ctr_r_o(ctr[1]), .overflow_r_o(ovf[1]), .snap_v_i(snap_v_i),
    .snap_v_o(sv[1]), .snap_data_o(sd[1]), .snap_yumi_i(snap_yumi_i));

  bsg_cycle_counter_snap #(.width_p(8), .init_val_p(8'h10), .saturate_p(0)) dut_c (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i), .load_v_i(load_v_i),
    .load_data_i(load_data_i), .ctr_r_o(ctr[2]), .overflow_r_o(ovf[2]), .snap_v_i(snap_v_i),
    .snap_v_o(sv[2]), .snap_data_o(sd[2]), .snap_yumi_i(snap_yumi_i));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next state straight from the priority rules.
  always @(posedge clk) begin
    if (reset_i) begin
      model_ok <= 1'b1;
      m_sv     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_ctr[i] <= init_m[i];
        m_ovf[i] <= 1'b0;
        m_sd[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clear_i) begin
          m_ctr[i] <= init_m[i];
          m_ovf[i] <= 1'b0;
        end else if (load_v_i) begin
          m_ctr[i] <= int'(load_data_i);
        end else if (en_i) begin
          if (m_ctr[i] == 255) begin
            m_ovf[i] <= 1'b1;
            m_ctr[i] <= sat_m[i] ? 255 : 0;
          end else begin
            m_ctr[i] <= m_ctr[i] + 1;
          end
        end
      end
      if (snap_en_lp) begin
        if (snap_v_i && (!m_sv || snap_yumi_i)) begin
          m_sv <= 1'b1;
          for (int i = 0; i < 3; i++) m_sd[i] <= m_ctr[i];
        end else if (snap_yumi_i) begin
          m_sv <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_ctr%0d", i), int'(ctr[i]), m_ctr[i]);
        chk($sformatf("model_ovf%0d", i), int'(ovf[i]), int'(m_ovf[i]));
        chk($sformatf("model_snap_v%0d", i), int'(sv[i]), int'(m_sv));
        chk($sformatf("model_snap_data%0d", i), int'(sd[i]), m_sd[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    reset_i = 1'b0; en_i = 1'b0; clear_i = 1'b0; load_v_i = 1'b0;
    snap_v_i = 1'b0; snap_yumi_i = 1'b0;
  endtask

  int exp_sv;
  int exp_sd;

  initial begin
    tick(); tick();
    chk("reset_ctr_w", int'(ctr[0]), 8'h00);
    chk("reset_ctr_c", int'(ctr[2]), 8'h10);
    chk("reset_ovf_w", int'(ovf[0]), 0);
    chk("reset_snap_v", int'(sv[0]), 0);
    idle();

    // Wrap and saturate boundaries
    load_v_i = 1'b1; load_data_i = 8'hFE; tick(); idle();
    chk("load_fe", int'(ctr[0]), 8'hFE);
    en_i = 1'b1;
    tick();
    chk("wrap_c1", int'(ctr[0]), 8'hFF); chk("wrap_o1", int'(ovf[0]), 0);
    chk("sat_c1", int'(ctr[1]), 8'hFF);  chk("sat_o1", int'(ovf[1]), 0);
    tick();
    chk("wrap_c2", int'(ctr[0]), 8'h00); chk("wrap_o2", int'(ovf[0]), 1);
    chk("sat_c2", int'(ctr[1]), 8'hFF);  chk("sat_o2", int'(ovf[1]), 1);
    tick();
    chk("wrap_c3", int'(ctr[0]), 8'h01); chk("wrap_o3", int'(ovf[0]), 1);
    chk("sat_c3", int'(ctr[1]), 8'hFF);  chk("sat_o3", int'(ovf[1]), 1);
    idle();

    // Priority
    clear_i = 1'b1; load_v_i = 1'b1; load_data_i = 8'h55; en_i = 1'b1; tick();
    chk("prio_clear_c", int'(ctr[2]), 8'h10); chk("prio_clear_o", int'(ovf[2]), 0);
    chk("prio_clear_w", int'(ctr[0]), 8'h00); chk("prio_clear_ow", int'(ovf[0]), 0);
    clear_i = 1'b0; tick();
    chk("prio_load", int'(ctr[2]), 8'h55);
    idle();

    // Snapshot handshake
    load_v_i = 1'b1; load_data_i = 8'h20; tick(); idle();
    en_i = 1'b1; snap_v_i = 1'b1; tick();
    snap_v_i = 1'b0;
    exp_sv = snap_en_lp ? 1 : 0;
    exp_sd = snap_en_lp ? 8'h20 : 0;
    for (int k = 0; k < 3; k++) begin
      snap_v_i = (ctr[0] == 8'h22);
      tick();
      chk("snap_hold_v", int'(sv[0]), exp_sv);
      chk("snap_hold_d", int'(sd[0]), exp_sd);
    end
    chk("snap_ctr24", int'(ctr[0]), 8'h24);
    snap_v_i = 1'b1; snap_yumi_i = snap_en_lp; tick();
    chk("snap_swap_v", int'(sv[0]), exp_sv);
    chk("snap_swap_d", int'(sd[0]), snap_en_lp ? 8'h24 : 0);
    snap_v_i = 1'b0; tick();
    chk("snap_drain_v", int'(sv[0]), 0);
    idle();

    // Reset mid-operation with overflow set and a pending snapshot
    load_v_i = 1'b1; load_data_i = 8'hFF; tick(); idle();
    en_i = 1'b1; tick(); idle();
    load_v_i = 1'b1; load_data_i = 8'h80; tick(); idle();
    snap_v_i = 1'b1; tick(); idle();
    chk("pre_rst_ctr", int'(ctr[0]), 8'h80);
    chk("pre_rst_ovf", int'(ovf[0]), 1);
    chk("pre_rst_sv", int'(sv[0]), exp_sv);
    reset_i = 1'b1; en_i = 1'b1; load_v_i = 1'b1; snap_v_i = 1'b1; tick(); idle();
    chk("rst_ctr", int'(ctr[0]), 0); chk("rst_ovf", int'(ovf[0]), 0);
    chk("rst_sv", int'(sv[0]), 0);   chk("rst_sd", int'(sd[0]), 0);
    en_i = 1'b1; tick(); idle();
    chk("resume_ctr", int'(ctr[0]), 1);

    // Randomized traffic biased toward the all-ones boundary
    for (int k = 0; k < 3000; k++) begin
      reset_i     = ($urandom % 150) == 0;
      clear_i     = ($urandom % 40) == 0;
      load_v_i    = ($urandom % 8) == 0;
      load_data_i = (($urandom % 3) == 0) ? 8'(8'hF8 + $urandom % 8) : 8'($urandom);
      en_i        = ($urandom % 4) != 0;
      snap_v_i    = ($urandom % 3) == 0;
      snap_yumi_i = m_sv && (($urandom % 2) == 0);
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
